// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Feeds the seg7 decoders: 4-bit digit slices plus a leading-zero blank mask.

// Per-digit "add 3 if >= 5" correction applied before each shift.
module bin_to_bcd_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_fit();
    longint unsigned p;
    p = 1;
    if (DIGITS >= 20) return 1'b1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    if (WIDTH >= 64) return 1'b0;
    return p > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  localparam bit FIT = digits_fit();

  generate
    if (!FIT) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  bin_reg;
  logic [BW-1:0]     scr, adj, scr_nxt;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] blank_nxt;
  logic              last, accept;

  // Digit correctors, one per BCD digit of the scratch.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bin_to_bcd_digit u_adj (.d(scr[4*g +: 4]), .q(adj[4*g +: 4]));
    end
  endgenerate

  // MSB of the binary register shifts into the units digit LSB.
  assign scr_nxt = {adj[BW-2:0], bin_reg[WIDTH-1]};
  assign last    = (cnt == CW'(WIDTH - 1));
  assign accept  = start && (state != SHIFT);
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);

  // Leading-zero mask of the result about to be loaded; units never blanked.
  always_comb begin
    blank_nxt = '0;
    for (int i = 1; i < DIGITS; i++)
      blank_nxt[i] = ~|(scr_nxt >> (4 * i));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: restart allowed from DONE for back-to-back conversions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift while busy, publish on last shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg <= '0;
      scr     <= '0;
      cnt     <= '0;
      bcd     <= '0;
      blank   <= BLANK_RST;
    end else if (accept) begin
      bin_reg <= bin;
      scr     <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      bin_reg <= bin_reg << 1;
      scr     <= scr_nxt;
      cnt     <= cnt + 1'b1;
      if (last) begin
        bcd   <= scr_nxt;
        blank <= blank_nxt;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results,
// a monitor pops and checks on every done pulse.
module tb_bin_to_bcd_seq;
  logic        clk = 0, rst = 1, start = 0;
  logic [15:0] bin = 0;
  logic        busy, done;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int tests = 0, fails = 0, ndone = 0, npush = 0;
  logic [24:0] exp_q[$];

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(posedge clk) begin
    #1;
    if (done) begin
      ndone++;
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        chk("bcd", 32'(bcd), 32'(e[24:5]));
        chk("blank", 32'(blank), 32'(e[4:0]));
      end
    end
  end

  task automatic issue(input logic [15:0] v, input logic [19:0] eb,
                       input logic [4:0] ebl, input bit push);
    @(negedge clk);
    start = 1; bin = v;
    if (push) begin exp_q.push_back({eb, ebl}); npush++; end
    @(negedge clk);
    start = 0; bin = 16'($urandom);
  endtask

  // Counts edges until done (bounded) and busy samples before it.
  task automatic wait_done(output int n, output int nbusy);
    bit seen = 0;
    n = 0; nbusy = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
      else if (busy) nbusy++;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), 32'h0);
    chk({tag, "_blank"}, 32'(blank), 32'b11110);
  endtask

  initial begin
    int n, nb;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    check_reset_vals("reset");

    // Zero input: full latency and busy-length checks.
    issue(16'd0, 20'h00000, 5'b11110, 1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_done(n, nb);
    chk("latency", 32'(n), 32'd16);
    chk("busy_cycles", 32'(nb), 32'd15);
    chk("busy_in_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_width", 32'(done), 32'd0);

    issue(16'd1234,  20'h01234, 5'b10000, 1); wait_done(n, nb);
    issue(16'd65535, 20'h65535, 5'b00000, 1); wait_done(n, nb);
    issue(16'd9,     20'h00009, 5'b11110, 1); wait_done(n, nb);
    issue(16'd10000, 20'h10000, 5'b00000, 1); wait_done(n, nb);
    issue(16'd100,   20'h00100, 5'b11000, 1); wait_done(n, nb);

    // Start during SHIFT must be ignored.
    issue(16'd500, 20'h00500, 5'b11000, 1);
    repeat (4) @(negedge clk);
    start = 1; bin = 16'd7;
    @(negedge clk); start = 0;
    wait_done(n, nb);
    repeat (20) @(negedge clk);

    // Back-to-back: start held through the DONE cycle.
    issue(16'd1234, 20'h01234, 5'b10000, 1);
    wait_done(n, nb);
    start = 1; bin = 16'd42;
    exp_q.push_back({20'h00042, 5'b11100}); npush++;
    @(posedge clk); #1;
    chk("b2b_busy", 32'(busy), 32'd1);
    start = 0; bin = 16'hffff;
    wait_done(n, nb);
    chk("b2b_spacing", 32'(n + 1), 32'd17);

    // Reset mid-conversion: no done, reset values immediately.
    issue(16'd999, 20'h0, 5'b0, 0);
    repeat (8) @(posedge clk);
    #3 rst = 1;
    #1 check_reset_vals("midrst");
    @(negedge clk); rst = 0;
    repeat (20) @(negedge clk);
    check_reset_vals("postrst");
    issue(16'd999, 20'h00999, 5'b11000, 1); wait_done(n, nb);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(ndone), 32'(npush));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
